word_count_unit: RTL and testbench

- Word-count datapath stage of the DMA address generator. Holds the 8-bit word register, the 8-bit word counter, the 2-bit mode control register and the count-enable state.
- Drives dowr, dowc and mode into the downstream done generator.
- Consumes that generator's done output to freeze counting.
- Executes the word-side subset of the 3-bit instruction set and provides registered readback.

---
 rtl/word_count_unit.sv | 147 ++++++++++++++
 tb/tb_word_count_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/word_count_unit.sv
// Word-count datapath stage of the DMA address generator.
// Holds the word register, the word counter, the mode control field and the
// count-enable state. It executes the word-side instructions and provides
// registered readback. The downstream done generator closes the loop through
// the done input.
module word_count_unit #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   instr,
  input  logic         instr_vld,
  input  logic [W-1:0] din,
  input  logic         cinw,
  input  logic         done,
  output logic [W-1:0] dowc,
  output logic [W-1:0] dowr,
  output logic [1:0]   mode,
  output logic         running,
  output logic         halted,
  output logic [W-1:0] dout,
  output logic         dout_vld
);

  localparam logic [2:0] OpWrcr   = 3'b000;
  localparam logic [2:0] OpRdcr   = 3'b001;
  localparam logic [2:0] OpRdwc   = 3'b010;
  localparam logic [2:0] OpRdwr   = 3'b011;
  localparam logic [2:0] OpReinit = 3'b100;
  localparam logic [2:0] OpAddr   = 3'b101;
  localparam logic [2:0] OpLdwc   = 3'b110;
  localparam logic [2:0] OpEnct   = 3'b111;

  localparam logic [W-1:0] One = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    StStop = 2'b00,
    StRun  = 2'b01,
    StHalt = 2'b10
  } state_e;

  state_e         state_q;
  logic [W-1:0]   dowc_q;
  logic [W-1:0]   dowr_q;
  logic [1:0]     mode_q;
  logic [W-1:0]   dout_q;
  logic           dout_vld_q;

  logic [W-1:0]   reload_cur;
  logic [W-1:0]   reload_din;
  logic [W-1:0]   dowc_step;
  logic [W-1:0]   mode_rd;
  logic           is_read;
  logic           cnt_slot;

  // Reload targets, counter step value and which edges leave room for counting.
  always_comb begin
    // Odd modes reload to zero, even modes reload to the word register.
    reload_cur = mode_q[0] ? '0 : dowr_q;
    // LDWC evaluates the reload with the incoming word as the register value.
    reload_din = mode_q[0] ? '0 : din;

    dowc_step = dowc_q;
    unique case (mode_q)
      2'b00:   dowc_step = dowc_q - One;
      2'b01,
      2'b11:   dowc_step = dowc_q + One;
      default: dowc_step = dowc_q;  // mode 10: counter is only the compare reference
    endcase

    mode_rd = {{(W-2){1'b0}}, mode_q};

    is_read = instr_vld && ((instr == OpRdcr) || (instr == OpRdwc) || (instr == OpRdwr));
    // Reads and the address-side opcode leave counting alone; any other
    // executed instruction swallows that edge's count step.
    cnt_slot = !instr_vld || is_read || (instr == OpAddr);
  end

  // All state: reset, then counting, then instruction writes (later wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStop;
      dowc_q     <= '0;
      dowr_q     <= '0;
      mode_q     <= 2'b00;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;

      if (cnt_slot && (state_q == StRun)) begin
        // done freezes the counter on this very edge regardless of cinw.
        if (done) begin
          state_q <= StHalt;
        end else if (cinw) begin
          dowc_q <= dowc_step;
        end
      end

      if (instr_vld) begin
        unique case (instr)
          OpWrcr: begin
            mode_q  <= din[1:0];
            state_q <= StStop;
          end
          OpRdcr: begin
            dout_q     <= mode_rd;
            dout_vld_q <= 1'b1;
          end
          OpRdwc: begin
            dout_q     <= dowc_q;
            dout_vld_q <= 1'b1;
          end
          OpRdwr: begin
            dout_q     <= dowr_q;
            dout_vld_q <= 1'b1;
          end
          OpReinit: begin
            dowc_q  <= reload_cur;
            state_q <= StStop;
          end
          OpAddr: begin
          end
          OpLdwc: begin
            dowr_q  <= din;
            dowc_q  <= reload_din;
            state_q <= StStop;
          end
          OpEnct: begin
            state_q <= StRun;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign dowc     = dowc_q;
  assign dowr     = dowr_q;
  assign mode     = mode_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign running  = (state_q == StRun);
  assign halted   = (state_q == StHalt);

endmodule

// File: tb/tb_word_count_unit.sv
// Self-checking bench for word_count_unit: a table of single-edge vectors
// followed by hand-written multi-cycle sequences for wrap, collision and reset.
module tb_word_count_unit;

  logic       clk;
  logic       rst;
  logic [2:0] instr;
  logic       instr_vld;
  logic [7:0] din;
  logic       cinw;
  logic       done;
  logic [7:0] dowc;
  logic [7:0] dowr;
  logic [1:0] mode;
  logic       running;
  logic       halted;
  logic [7:0] dout;
  logic       dout_vld;

  logic       force_done0;
  int         n_pass;
  int         n_total;

  word_count_unit #(.W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .instr_vld (instr_vld),
    .din       (din),
    .cinw      (cinw),
    .done      (done),
    .dowc      (dowc),
    .dowr      (dowr),
    .mode      (mode),
    .running   (running),
    .halted    (halted),
    .dout      (dout),
    .dout_vld  (dout_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the downstream done generator.
  always_comb begin
    done = 1'b0;
    if (!force_done0) begin
      case (mode)
        2'b00:   done = ((dowc == 8'h01) && !cinw) || ((dowc == 8'h00) && cinw);
        2'b01:   done = (dowc == dowr);
        default: done = 1'b0;
      endcase
    end
  end

  typedef struct {
    logic       vld;
    logic [2:0] op;
    logic [7:0] d;
    logic       c;
    logic [7:0] e_dowc;
    logic [7:0] e_dowr;
    logic [1:0] e_mode;
    logic       e_run;
    logic       e_halt;
    logic       e_vld;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [7:0] d, input logic c);
    instr_vld = v;
    instr     = op;
    din       = d;
    cinw      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_dowc, input logic [7:0] e_dowr,
                         input logic [1:0] e_mode, input logic e_run, input logic e_halt,
                         input logic e_vld, input logic [7:0] e_dout);
    chk({tag, " dowc"}, 32'(dowc), 32'(e_dowc));
    chk({tag, " dowr"}, 32'(dowr), 32'(e_dowr));
    chk({tag, " mode"}, 32'(mode), 32'(e_mode));
    chk({tag, " running"}, 32'(running), 32'(e_run));
    chk({tag, " halted"}, 32'(halted), 32'(e_halt));
    chk({tag, " dout_vld"}, 32'(dout_vld), 32'(e_vld));
    chk({tag, " dout"}, 32'(dout), 32'(e_dout));
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    force_done0 = 1'b0;

    //          vld  op    din    cinw | dowc   dowr   mode  run   halt  vld   dout
    tbl[0]  = '{1'b1, 3'd0, 8'h00, 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 3'd6, 8'h03, 1'b0, 8'h03, 8'h03, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 3'd7, 8'h00, 1'b0, 8'h03, 8'h03, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[3]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h02, 8'h03, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h01, 8'h03, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h03, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[6]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h03, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[7]  = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h03, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 3'd2, 8'h00, 1'b0, 8'h00, 8'h03, 2'd0, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[9]  = '{1'b0, 3'd0, 8'h00, 1'b0, 8'h00, 8'h03, 2'd0, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[10] = '{1'b1, 3'd3, 8'h00, 1'b0, 8'h00, 8'h03, 2'd0, 1'b0, 1'b1, 1'b1, 8'h03};
    tbl[11] = '{1'b1, 3'd1, 8'h00, 1'b0, 8'h00, 8'h03, 2'd0, 1'b0, 1'b1, 1'b1, 8'h00};
    tbl[12] = '{1'b1, 3'd0, 8'h01, 1'b0, 8'h00, 8'h03, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 3'd6, 8'h05, 1'b0, 8'h00, 8'h05, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[14] = '{1'b1, 3'd7, 8'h00, 1'b0, 8'h00, 8'h05, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[15] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h01, 8'h05, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[16] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h02, 8'h05, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[17] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h03, 8'h05, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[18] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h04, 8'h05, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[19] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h05, 8'h05, 2'd1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[20] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h05, 8'h05, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[21] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h05, 8'h05, 2'd1, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[22] = '{1'b1, 3'd1, 8'h00, 1'b0, 8'h05, 8'h05, 2'd1, 1'b0, 1'b1, 1'b1, 8'h01};
    tbl[23] = '{1'b1, 3'd4, 8'h00, 1'b0, 8'h00, 8'h05, 2'd1, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[24] = '{1'b0, 3'd0, 8'h00, 1'b1, 8'h00, 8'h05, 2'd1, 1'b0, 1'b0, 1'b0, 8'h01};
    tbl[25] = '{1'b1, 3'd5, 8'hAB, 1'b1, 8'h00, 8'h05, 2'd1, 1'b0, 1'b0, 1'b0, 8'h01};

    // Reset held two cycles with garbage on the inputs.
    rst = 1'b1;
    step(1'b1, 3'd6, 8'hA5, 1'b1);
    step(1'b1, 3'd7, 8'h5A, 1'b1);
    chk_all("reset", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;

    // Mode 00 count-down to halt, readback, mode 01 count-up to halt, REINIT.
    for (int i = 0; i < 26; i++) begin
      step(tbl[i].vld, tbl[i].op, tbl[i].d, tbl[i].c);
      chk_all($sformatf("row%0d", i), tbl[i].e_dowc, tbl[i].e_dowr, tbl[i].e_mode,
              tbl[i].e_run, tbl[i].e_halt, tbl[i].e_vld, tbl[i].e_dout);
    end

    // Mode 11 wraps FF -> 00 and keeps running.
    step(1'b1, 3'd0, 8'h03, 1'b0);
    step(1'b1, 3'd6, 8'h00, 1'b0);
    step(1'b1, 3'd4, 8'h00, 1'b0);
    step(1'b1, 3'd7, 8'h00, 1'b0);
    for (int i = 0; i < 255; i++) step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("m11 preload dowc", 32'(dowc), 32'h0000_00FF);
    chk("m11 preload running", 32'(running), 32'd1);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("m11 wrap dowc", 32'(dowc), 32'h0000_0000);
    chk("m11 wrap running", 32'(running), 32'd1);

    // Mode write during RUN drops to STOP without reloading; count step lost.
    step(1'b1, 3'd0, 8'h00, 1'b1);
    chk("wrcr in run running", 32'(running), 32'd0);
    chk("wrcr in run dowc", 32'(dowc), 32'h0000_0000);
    chk("wrcr in run mode", 32'(mode), 32'd0);

    // Mode 00 wraps 00 -> FF with done held low.
    force_done0 = 1'b1;
    step(1'b1, 3'd7, 8'h00, 1'b0);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("m00 wrap dowc", 32'(dowc), 32'h0000_00FF);

    // RDWC colliding with a count step in mode 01.
    step(1'b1, 3'd0, 8'h01, 1'b0);
    step(1'b1, 3'd6, 8'h40, 1'b0);
    chk("ldwc m01 dowc", 32'(dowc), 32'h0000_0000);
    step(1'b1, 3'd7, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("m01 count dowc", 32'(dowc), 32'h0000_0010);
    step(1'b1, 3'd2, 8'h00, 1'b1);
    chk("rdwc coll dout", 32'(dout), 32'h0000_0010);
    chk("rdwc coll vld", 32'(dout_vld), 32'd1);
    chk("rdwc coll dowc", 32'(dowc), 32'h0000_0011);
    chk("rdwc coll running", 32'(running), 32'd1);
    step(1'b0, 3'd0, 8'h00, 1'b0);
    chk("vld drops", 32'(dout_vld), 32'd0);
    chk("dout holds", 32'(dout), 32'h0000_0010);

    // ENCT with cinw on the same edge: RUN but no step.
    step(1'b1, 3'd0, 8'h00, 1'b0);
    step(1'b1, 3'd7, 8'h00, 1'b1);
    chk("enct cinw running", 32'(running), 32'd1);
    chk("enct cinw dowc", 32'(dowc), 32'h0000_0011);

    // LDWC colliding with a count step in mode 00.
    step(1'b1, 3'd6, 8'h20, 1'b1);
    chk("ldwc coll dowr", 32'(dowr), 32'h0000_0020);
    chk("ldwc coll dowc", 32'(dowc), 32'h0000_0020);
    chk("ldwc coll running", 32'(running), 32'd0);

    // Reset in the middle of RUN.
    step(1'b1, 3'd6, 8'h7A, 1'b0);
    step(1'b1, 3'd7, 8'h00, 1'b0);
    chk("pre-rst running", 32'(running), 32'd1);
    chk("pre-rst dowc", 32'(dowc), 32'h0000_007A);
    rst = 1'b1;
    step(1'b0, 3'd0, 8'h00, 1'b1);
    rst = 1'b0;
    chk_all("midrst", 8'h00, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("post-rst idle dowc", 32'(dowc), 32'h0000_0000);
    chk("post-rst idle running", 32'(running), 32'd0);
    step(1'b1, 3'd7, 8'h00, 1'b1);
    chk("post-rst enct dowc", 32'(dowc), 32'h0000_0000);
    step(1'b0, 3'd0, 8'h00, 1'b1);
    chk("post-rst count dowc", 32'(dowc), 32'h0000_00FF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
